// File: rtl/fetch_rf_arb_ctrl.sv
// Port arbiter and read-return sequencer for the single-port fetch reference RF.
// Optional output data register: define FETCH_ARB_RDHOLD_EN (2-cycle read latency).

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module fetch_rf_arb_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32 * `PIXEL_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ack_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [3:0]            rd_tag_i,
    output logic                  rd_ack_o,
    output logic                  rd_valid_o,
    output logic [3:0]            rd_tag_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       gnt_wr;
    logic       gnt_rd;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;
    logic       force_rd;
    logic       force_rd_nxt;

    // Grant selection: forced read, else write priority, else read.
    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (rstn) begin
            if (force_rd && rd_req_i) begin
                gnt_rd = 1'b1;
            end else if (wr_req_i) begin
                gnt_wr = 1'b1;
            end else if (rd_req_i) begin
                gnt_rd = 1'b1;
            end
        end
    end

    assign wr_ack_o = gnt_wr;
    assign rd_ack_o = gnt_rd;

    // RF port drive; address/data zeroed when the enable is low.
    always_comb begin
        mem_wr_en_o   = gnt_wr;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        mem_rd_en_o   = gnt_rd;
        mem_rd_addr_o = '0;
        if (gnt_wr) begin
            mem_wr_addr_o = wr_addr_i;
            mem_wr_data_o = wr_data_i;
        end
        if (gnt_rd) begin
            mem_rd_addr_o = rd_addr_i;
        end
    end

    // Count denied read cycles; arm a forced read once the limit is hit.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        force_rd_nxt   = force_rd;
        if (!rd_req_i || gnt_rd) begin
            starve_cnt_nxt = '0;
            force_rd_nxt   = 1'b0;
        end else begin
            if (starve_cnt != 4'hF) begin
                starve_cnt_nxt = starve_cnt + 4'd1;
            end
            if (starve_cnt_nxt >= STARVE_LIM) begin
                force_rd_nxt = 1'b1;
            end
        end
    end

    // Starvation state registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
            force_rd   <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            force_rd   <= force_rd_nxt;
        end
    end

`ifdef FETCH_ARB_RDHOLD_EN

    logic                  vld_s1;
    logic [3:0]            tag_s1;
    logic                  vld_s2;
    logic [3:0]            tag_s2;
    logic [DATA_WIDTH-1:0] data_q;

    // Two-stage return pipe; data captured when the RF output is valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_s1 <= 1'b0;
            tag_s1 <= '0;
            vld_s2 <= 1'b0;
            tag_s2 <= '0;
            data_q <= '0;
        end else begin
            vld_s1 <= gnt_rd;
            if (gnt_rd) begin
                tag_s1 <= rd_tag_i;
            end
            vld_s2 <= vld_s1;
            if (vld_s1) begin
                tag_s2 <= tag_s1;
                data_q <= mem_rd_data_i;
            end
        end
    end

    assign rd_valid_o = vld_s2 & rstn;
    assign rd_tag_o   = tag_s2;
    assign rd_data_o  = data_q;

`else

    logic       vld_s1;
    logic [3:0] tag_s1;

    // One-stage return pipe; data passes straight through from the RF.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_s1 <= 1'b0;
            tag_s1 <= '0;
        end else begin
            vld_s1 <= gnt_rd;
            if (gnt_rd) begin
                tag_s1 <= rd_tag_i;
            end
        end
    end

    assign rd_valid_o = vld_s1 & rstn;
    assign rd_tag_o   = tag_s1;
    assign rd_data_o  = mem_rd_data_i;

`endif

endmodule

// File: tb/tb_fetch_rf_arb_ctrl.sv
// Randomized self-checking bench for fetch_rf_arb_ctrl.
// Reference: request-level grant rules, shadow RF and return queue.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_fetch_rf_arb_ctrl;

    localparam int AW = 6;
    localparam int DW = 32 * `PIXEL_WIDTH;
    localparam int SMAX = 4;
`ifdef FETCH_ARB_RDHOLD_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_tag;
    logic          rd_ack;
    logic          rd_valid;
    logic [3:0]    rd_tag_o;
    logic [DW-1:0] rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;

    fetch_rf_arb_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .wr_req_i(wr_req),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .wr_ack_o(wr_ack),
        .rd_req_i(rd_req),
        .rd_addr_i(rd_addr),
        .rd_tag_i(rd_tag),
        .rd_ack_o(rd_ack),
        .rd_valid_o(rd_valid),
        .rd_tag_o(rd_tag_o),
        .rd_data_o(rd_data),
        .mem_wr_en_o(mem_wr_en),
        .mem_wr_addr_o(mem_wr_addr),
        .mem_wr_data_o(mem_wr_data),
        .mem_rd_en_o(mem_rd_en),
        .mem_rd_addr_o(mem_rd_addr),
        .mem_rd_data_i(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Single-port RF with one-cycle registered read.
    logic [DW-1:0] rf [64];
    always @(posedge clk) begin
        if (mem_wr_en) rf[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= rf[mem_rd_addr];
    end

    typedef struct {
        int            due;
        logic [3:0]    tag;
        logic [DW-1:0] data;
    } ret_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            m_wait = 0;
    int            m_last = 0;
    logic [DW-1:0] shadow [64];
    ret_t          expq [$];

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [DW-1:0] rep8(input logic [7:0] b);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 8; i++) w[i*8 +: 8] = b;
        return w;
    endfunction

    // 0 idle, 1 write, 2 read -- from the request-level priority rules.
    function automatic int model_grant();
        if (!rstn) return 0;
        if (rd_req && m_wait >= SMAX) return 2;
        if (wr_req) return 1;
        if (rd_req) return 2;
        return 0;
    endfunction

    function automatic logic exp_valid();
        return rstn && expq.size() > 0 && expq[0].due == cyc;
    endfunction

    // Advance one clock and update the reference model.
    task automatic cycle();
        int g;
        g = model_grant();
        @(posedge clk);
        if (!rstn) begin
            m_wait = 0;
            expq.delete();
        end else begin
            if (g == 1) shadow[wr_addr] = wr_data;
            if (g == 2) expq.push_back('{cyc + LAT, rd_tag, shadow[rd_addr]});
            m_wait = (rd_req && g != 2) ? m_wait + 1 : 0;
        end
        if (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());
        cyc++;
        m_last = g;
        #1;
    endtask

    task automatic idle_inputs();
        wr_req = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0; rd_tag = '0;
    endtask

    task automatic test_reset();
        rstn = 0;
        wr_req = 1; rd_req = 1; wr_addr = 6'd1; rd_addr = 6'd2;
        @(negedge clk);
        checks++;
        if ({wr_ack, rd_ack, mem_wr_en, mem_rd_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_gate got=%b exp=0000", {wr_ack, rd_ack, mem_wr_en, mem_rd_en});
        end
        cycle();
        cycle();
        idle_inputs();
        rstn = 1;
        @(negedge clk);
        checks++;
        if ({wr_ack, rd_ack, mem_wr_en, mem_rd_en, rd_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=00000", {wr_ack, rd_ack, mem_wr_en, mem_rd_en, rd_valid});
        end
        checks++;
        if (dut.starve_cnt !== 4'd0 || dut.force_rd !== 1'b0) begin
            failures++;
            $display("FAIL reset_starve got=%0d/%b exp=0/0", dut.starve_cnt, dut.force_rd);
        end
`ifdef FETCH_ARB_RDHOLD_EN
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", rd_data);
        end
`endif
        cycle();
    endtask

    task automatic test_read_basic();
        wr_req = 1; wr_addr = 6'd5; wr_data = rep8(8'hA5);
        @(negedge clk);
        checks++;
        if (wr_ack !== 1 || mem_wr_en !== 1 || mem_wr_addr !== 6'd5 || mem_wr_data !== rep8(8'hA5)) begin
            failures++;
            $display("FAIL preload_wr got=%b%b a=%0d exp=11 a=5", wr_ack, mem_wr_en, mem_wr_addr);
        end
        cycle();
        idle_inputs();
        rd_req = 1; rd_addr = 6'd5; rd_tag = 4'd3;
        @(negedge clk);
        checks++;
        if (rd_ack !== 1 || mem_rd_en !== 1 || mem_rd_addr !== 6'd5 || wr_ack !== 0) begin
            failures++;
            $display("FAIL rd_grant got=%b%b%b a=%0d exp=110 a=5", rd_ack, mem_rd_en, wr_ack, mem_rd_addr);
        end
        cycle();
        idle_inputs();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== (k == LAT)) begin
                failures++;
                $display("FAIL rd_latency k=%0d got=%b exp=%b", k, rd_valid, k == LAT);
            end
            if (k == LAT) begin
                checks++;
                if (rd_tag_o !== 4'd3 || rd_data !== rep8(8'hA5)) begin
                    failures++;
                    $display("FAIL rd_data got=%0d/%h exp=3/%h", rd_tag_o, rd_data, rep8(8'hA5));
                end
            end
            cycle();
        end
    endtask

    task automatic test_ordering();
        wr_req = 1; wr_addr = 6'd10; wr_data = rep8(8'h11);
        @(negedge clk);
        cycle();
        idle_inputs();
        rd_req = 1; rd_addr = 6'd10; rd_tag = 4'd7;
        @(negedge clk);
        cycle();
        rd_req = 1; rd_addr = 6'd10; rd_tag = 4'd8;
        @(negedge clk);
        checks++;
        if (rd_ack !== 1) begin
            failures++;
            $display("FAIL war_rd_ack got=%b exp=1", rd_ack);
        end
        cycle();
        idle_inputs();
        wr_req = 1; wr_addr = 6'd10; wr_data = rep8(8'h22);
        for (int k = 2; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                checks++;
                if (!rd_valid || rd_tag_o !== 4'd7 || rd_data !== rep8(8'h11)) begin
                    failures++;
                    $display("FAIL raw_data got=%b/%0d/%h exp=1/7/%h", rd_valid, rd_tag_o, rd_data, rep8(8'h11));
                end
            end
            if (k == LAT + 1) begin
                checks++;
                if (!rd_valid || rd_tag_o !== 4'd8 || rd_data !== rep8(8'h11)) begin
                    failures++;
                    $display("FAIL war_data got=%b/%0d/%h exp=1/8/%h", rd_valid, rd_tag_o, rd_data, rep8(8'h11));
                end
            end
            cycle();
            wr_req = 0;
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_starvation();
        int nbad;
        nbad = 0;
        wr_req = 1; wr_addr = 6'd20; wr_data = rnd_word();
        rd_req = 1; rd_addr = 6'd21; rd_tag = 4'd1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checks++;
            if (rd_ack !== (k % 5 == 4) || wr_ack !== (k % 5 != 4) || (mem_wr_en && mem_rd_en)) begin
                failures++;
                $display("FAIL starve_pattern k=%0d got=w%b r%b exp=w%b r%b", k, wr_ack, rd_ack, k % 5 != 4, k % 5 == 4);
            end
            cycle();
            if (m_last == 1) begin
                wr_addr = wr_addr + 1; wr_data = rnd_word();
            end
            if (m_last == 2) begin
                rd_tag = rd_tag + 1; rd_addr = rd_addr + 1;
            end
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_simultaneous();
        wr_req = 1; wr_addr = 6'd30; wr_data = rnd_word();
        rd_req = 1; rd_addr = 6'd31; rd_tag = 4'd9;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1 || rd_ack !== 0) begin
            failures++;
            $display("FAIL simul_grant got=w%b r%b exp=w1 r0", wr_ack, rd_ack);
        end
        cycle();
        wr_req = 0;
        @(negedge clk);
        checks++;
        if (dut.starve_cnt !== 4'd1 || rd_ack !== 1) begin
            failures++;
            $display("FAIL simul_starve got=%0d/%b exp=1/1", dut.starve_cnt, rd_ack);
        end
        cycle();
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_drop_force();
        wr_req = 1; wr_addr = 6'd40; wr_data = rnd_word();
        rd_req = 1; rd_addr = 6'd41; rd_tag = 4'd2;
        for (int k = 0; k < SMAX; k++) begin
            @(negedge clk);
            cycle();
            wr_data = rnd_word();
        end
        checks++;
        if (dut.force_rd !== 1'b1) begin
            failures++;
            $display("FAIL force_armed got=%b exp=1", dut.force_rd);
        end
        rd_req = 0;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1 || rd_ack !== 0) begin
            failures++;
            $display("FAIL drop_force got=w%b r%b exp=w1 r0", wr_ack, rd_ack);
        end
        cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (dut.force_rd !== 1'b0 || dut.starve_cnt !== 4'd0) begin
            failures++;
            $display("FAIL drop_clear got=%b/%0d exp=0/0", dut.force_rd, dut.starve_cnt);
        end
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_reset_inflight();
        rd_req = 1; rd_addr = 6'd5; rd_tag = 4'd4;
        @(negedge clk);
        checks++;
        if (rd_ack !== 1) begin
            failures++;
            $display("FAIL inflight_ack got=%b exp=1", rd_ack);
        end
        cycle();
        idle_inputs();
        rstn = 0;
        @(negedge clk);
        checks++;
        if (rd_valid !== 0) begin
            failures++;
            $display("FAIL inflight_rst got=%b exp=0", rd_valid);
        end
        cycle();
        rstn = 1;
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (rd_valid !== 0 || dut.starve_cnt !== 4'd0 || dut.force_rd !== 1'b0) begin
                failures++;
                $display("FAIL inflight_drop k=%0d got=%b/%0d/%b exp=0/0/0", k, rd_valid, dut.starve_cnt, dut.force_rd);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        int g;
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) rstn = 0;
            else rstn = 1;
            if (!wr_req || m_last == 1) begin
                wr_req = ($urandom % 100) < 60;
                wr_addr = 6'($urandom % 8);
                wr_data = rnd_word();
            end
            if (!rd_req || m_last == 2) begin
                rd_req = ($urandom % 100) < 55;
                rd_addr = 6'($urandom % 8);
                rd_tag = 4'($urandom);
            end
            @(negedge clk);
            g = model_grant();
            checks++;
            if (wr_ack !== (g == 1) || rd_ack !== (g == 2) || mem_wr_en !== (g == 1) || mem_rd_en !== (g == 2)) begin
                failures++;
                $display("FAIL rand_grant n=%0d got=w%b r%b exp=%0d", n, wr_ack, rd_ack, g);
            end
            checks++;
            if ((g == 1 && (mem_wr_addr !== wr_addr || mem_wr_data !== wr_data)) || (g == 2 && mem_rd_addr !== rd_addr)) begin
                failures++;
                $display("FAIL rand_mem n=%0d got=wa%0d ra%0d exp=wa%0d ra%0d", n, mem_wr_addr, mem_rd_addr, wr_addr, rd_addr);
            end
            checks++;
            if (rd_valid !== exp_valid()) begin
                failures++;
                $display("FAIL rand_valid n=%0d got=%b exp=%b", n, rd_valid, exp_valid());
            end else if (exp_valid()) begin
                checks++;
                if (rd_tag_o !== expq[0].tag || rd_data !== expq[0].data) begin
                    failures++;
                    $display("FAIL rand_data n=%0d got=%0d/%h exp=%0d/%h", n, rd_tag_o, rd_data, expq[0].tag, expq[0].data);
                end
            end
            cycle();
            if (!rstn) m_last = 3;
        end
        rstn = 1;
        idle_inputs();
        for (int k = 0; k < 3; k++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rf[i] = '0;
            shadow[i] = '0;
        end
        mem_rd_data = '0;
        idle_inputs();
        rstn = 0;
        test_reset();
        test_read_basic();
        test_ordering();
        test_starvation();
        test_simultaneous();
        test_drop_force();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
